fft_bin_collector: RTL

- Sink for the FFT core's final-stage output stream: valid, bin address, and two complex results per cycle.
- Buffers one full N-point frame and computes an L1 magnitude |re|+|im| per bin.
- Streams the N magnitudes out in natural bin order (0..N-1) over a valid/ready handshake to the vowel feature/classifier logic.

---
 rtl/fft_bin_collector.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/fft_bin_collector.sv
// fft_bin_collector: captures one N-point frame of FFT output pairs, stores an
// L1 magnitude (|re|+|im|) per bin at write time, then streams the N magnitudes
// in natural bin order over a valid/ready handshake.
module fft_bin_collector #(
  parameter int Q_IN   = 15,
  parameter int N      = 8,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  input  logic [ADDR_W-1:0]        addr_in,
  input  logic signed [Q_IN:0]     data_real_0,
  input  logic signed [Q_IN:0]     data_imag_0,
  input  logic signed [Q_IN:0]     data_real_1,
  input  logic signed [Q_IN:0]     data_imag_1,
  output logic                     in_ready,
  input  logic                     bin_ready,
  output logic                     bin_valid,
  output logic [ADDR_W-1:0]        bin_idx,
  output logic [Q_IN+1:0]          mag_out,
  output logic                     bin_last,
  output logic                     overflow,
  output logic                     addr_err
);

  localparam int MW   = Q_IN + 2;
  localparam int AW   = $clog2(N);
  localparam int HALF = N / 2;
  localparam logic [ADDR_W-1:0] HALF_A = ADDR_W'(HALF);
  localparam logic [AW-1:0]     LAST_C = AW'(N - 1);
  localparam logic [AW-1:0]     ZERO_C = '0;
  localparam logic [AW-1:0]     ONE_C  = AW'(1);

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_STREAM  = 1'b1
  } state_t;

  // Absolute value after sign extension by one bit, so -2^Q_IN maps cleanly
  // to +2^Q_IN without wrapping.
  function automatic logic [MW-1:0] abs_ext(input logic signed [Q_IN:0] x);
    logic [MW-1:0] e;
    e = {x[Q_IN], x};
    if (e[MW-1]) begin
      abs_ext = ~e + {{(MW-1){1'b0}}, 1'b1};
    end else begin
      abs_ext = e;
    end
  endfunction

  // L1 magnitude; the worst case 2^(Q_IN+1) still fits in MW bits.
  function automatic logic [MW-1:0] l1_mag(input logic signed [Q_IN:0] re,
                                           input logic signed [Q_IN:0] im);
    l1_mag = abs_ext(re) + abs_ext(im);
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic [MW-1:0]   r_mag [N];
  logic [HALF-1:0] r_mask;
  logic [HALF-1:0] w_mask_upd;
  logic [AW-1:0]   r_cnt;
  logic [AW-1:0]   w_cnt_inc;
  logic [AW-2:0]   w_lo;
  logic            w_addr_ok;
  logic            w_capture;
  logic            w_xfer;
  logic            w_final;
  logic            w_mask_full;
  logic [MW-1:0]   w_mag0;
  logic [MW-1:0]   w_mag1;

  logic              r_in_ready;
  logic              r_bin_valid;
  logic [ADDR_W-1:0] r_bin_idx;
  logic [MW-1:0]     r_mag_out;
  logic              r_bin_last;
  logic              r_overflow;
  logic              r_addr_err;

  assign w_lo        = addr_in[AW-2:0];
  assign w_addr_ok   = (addr_in < HALF_A);
  assign w_capture   = (r_state == S_COLLECT) && valid_in && w_addr_ok;
  assign w_xfer      = (r_state == S_STREAM) && r_bin_valid && bin_ready;
  assign w_final     = w_xfer && (r_cnt == LAST_C);
  assign w_cnt_inc   = r_cnt + ONE_C;
  assign w_mag0      = l1_mag(data_real_0, data_imag_0);
  assign w_mag1      = l1_mag(data_real_1, data_imag_1);
  assign w_mask_full = &w_mask_upd;

  assign in_ready  = r_in_ready;
  assign bin_valid = r_bin_valid;
  assign bin_idx   = r_bin_idx;
  assign mag_out   = r_mag_out;
  assign bin_last  = r_bin_last;
  assign overflow  = r_overflow;
  assign addr_err  = r_addr_err;

  // Fill mask as it would look after this cycle's capture.
  always_comb begin
    w_mask_upd = r_mask;
    if (w_capture) begin
      w_mask_upd[w_lo] = 1'b1;
    end else begin
      w_mask_upd = r_mask;
    end
  end

  // Next-state: leave COLLECT on the completing capture, leave STREAM on the last transfer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_COLLECT: begin
        if (w_capture && w_mask_full) begin
          w_state_nxt = S_STREAM;
        end else begin
          w_state_nxt = S_COLLECT;
        end
      end
      S_STREAM: begin
        if (w_final) begin
          w_state_nxt = S_COLLECT;
        end else begin
          w_state_nxt = S_STREAM;
        end
      end
      default: w_state_nxt = S_COLLECT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Magnitude buffer: bin k and bin k+N/2 written together; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mag[{1'b0, w_lo}] <= w_mag0;
      r_mag[{1'b1, w_lo}] <= w_mag1;
    end
  end

  // Fill mask, sticky error flags, and the registered output stream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mask      <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_bin_valid <= 1'b0;
      r_bin_idx   <= '0;
      r_mag_out   <= '0;
      r_bin_last  <= 1'b0;
      r_overflow  <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      r_in_ready <= (w_state_nxt == S_COLLECT);

      if (w_capture) begin
        r_mask <= w_mask_upd;
      end else if (w_final) begin
        r_mask <= '0;
      end

      if (valid_in && (r_state == S_STREAM)) begin
        r_overflow <= 1'b1;
      end
      if (valid_in && (r_state == S_COLLECT) && !w_addr_ok) begin
        r_addr_err <= 1'b1;
      end

      if (r_state == S_STREAM) begin
        if (!r_bin_valid) begin
          // First cycle in STREAM: present bin 0.
          r_bin_valid <= 1'b1;
          r_cnt       <= ZERO_C;
          r_bin_idx   <= '0;
          r_mag_out   <= r_mag[ZERO_C];
          r_bin_last  <= (ZERO_C == LAST_C);
        end else if (w_xfer) begin
          if (w_final) begin
            r_bin_valid <= 1'b0;
            r_bin_last  <= 1'b0;
          end else begin
            r_cnt      <= w_cnt_inc;
            r_bin_idx  <= ADDR_W'(w_cnt_inc);
            r_mag_out  <= r_mag[w_cnt_inc];
            r_bin_last <= (w_cnt_inc == LAST_C);
          end
        end
      end
    end
  end

endmodule
